// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite completer bus signal bundle
interface ahb_slave_mem_if;
  logic        hselx;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hreadyin;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  modport master (
    output hselx, haddr, hwrite, htrans, hsize, hburst, hreadyin, hwdata,
    input  hreadyout, hrdata, hresp
  );

  modport slave (
    input  hselx, haddr, hwrite, htrans, hsize, hburst, hreadyin, hwdata,
    output hreadyout, hrdata, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite completer with word memory, wait states and ERROR response
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input logic             hclk,
  input logic             hreset,
  ahb_slave_mem_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic [31:0]   offset;
  logic          addr_err;
  logic          accept;
  logic [3:0]    be;

  // Address-phase decode: offset into the bank and the error classification
  always_comb begin
    offset   = bus.haddr - BASE_ADDR;
    addr_err = (bus.hsize > 3'd2)
            || (bus.hsize == 3'd1 && bus.haddr[0])
            || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00)
            || (offset >= SPAN);
    // A new transfer is only taken while this slave itself is not stalling
    accept   = bus.hselx && bus.hreadyin && bus.htrans[1] && bus.hreadyout;
  end

  // Byte-lane enables for the captured write size and address
  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[lane_q] = 1'b1;
      3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Next-state, capture and bus outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    lane_d        = lane_q;
    size_d        = size_q;
    write_d       = write_q;
    bus.hreadyout = 1'b1;
    bus.hresp     = 2'b00;
    bus.hrdata    = 32'h0;
    case (state_q)
      S_WAIT: begin
        bus.hreadyout = 1'b0;
        if (cnt_q == 2'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 2'b01;
        state_d       = S_ERR2;
      end
      default: begin
        if (state_q == S_DONE && !write_q) bus.hrdata = mem_q[idx_q];
        if (state_q == S_ERR2)             bus.hresp  = 2'b01;
        if (accept) begin
          idx_d   = offset[AW+1:2];
          lane_d  = bus.haddr[1:0];
          size_d  = bus.hsize;
          write_d = bus.hwrite;
          cnt_d   = WS_LOAD;
          if (addr_err)              state_d = S_ERR1;
          else if (WAIT_STATES == 0) state_d = S_DONE;
          else                       state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Write lands on the edge that ends DONE, using hwdata sampled on that edge
  always_comb begin
    mem_d = mem_q;
    if (state_q == S_DONE && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_d[idx_q][8*k +: 8] = bus.hwdata[8*k +: 8];
      end
    end
  end

  // State and memory registers; reset aborts any transfer in flight
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
      mem_q   <= mem_d;
    end
  end

endmodule
